// File: rtl/int_rs_sched.sv
`default_nettype none
// ============================================================================
// Module      : int_rs_sched
// Description : Reservation station and issue scheduler for the 64-bit integer
//               add/sub functional unit. Buffers dispatched operations, wakes
//               pending operands from CDB broadcasts, issues one ready entry
//               per cycle (round-robin) to the combinational adder/subtractor
//               and holds the result until the CDB arbiter grants it.
// Ports       : clk, rst_n (async, active-low), flush (sync clear)
//               disp_*  : dispatch request / operands / destination tag
//               cdb_*   : common data bus broadcast (wakeup + forwarding)
//               fu_*    : operands to and result from the datapath
//               res_*   : registered result awaiting CDB, res_grant accepts it
//               perf_issue_cnt, perf_full_cnt : only with INT_RS_PERF_EN
// Options     : `define INT_RS_PERF_EN adds saturating performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module int_rs_sched #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 4,
    parameter int XLEN    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic             disp_op,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic [TAG_W-1:0] disp_qk,
    input  logic [XLEN-1:0]  disp_vj,
    input  logic [XLEN-1:0]  disp_vk,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             fu_op,
    output logic [XLEN-1:0]  fu_a,
    output logic [XLEN-1:0]  fu_b,
    input  logic [XLEN-1:0]  fu_res,
    input  logic             fu_bout,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic [XLEN-1:0]  res_data,
    output logic             res_bout,
`ifdef INT_RS_PERF_EN
    output logic [31:0]      perf_issue_cnt,
    output logic [31:0]      perf_full_cnt,
`endif
    input  logic             res_grant
);

    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Entry storage
    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_op;
    logic [TAG_W-1:0]   r_qj [ENTRIES];
    logic [TAG_W-1:0]   r_qk [ENTRIES];
    logic [XLEN-1:0]    r_vj [ENTRIES];
    logic [XLEN-1:0]    r_vk [ENTRIES];
    logic [TAG_W-1:0]   r_tag[ENTRIES];
    logic [PTR_W-1:0]   r_ptr;

    // Result register
    logic               r_res_valid;
    logic [TAG_W-1:0]   r_res_tag;
    logic [XLEN-1:0]    r_res_data;
    logic               r_res_bout;

    logic               w_free_found;
    logic [PTR_W-1:0]   w_free_idx;
    logic [ENTRIES-1:0] w_rdy;
    logic               w_sel_found;
    logic [PTR_W-1:0]   w_sel_idx;
    logic [PTR_W-1:0]   w_ptr_next;
    logic               w_issue;
    logic               w_disp;
    logic               w_cdb_hit;
    logic               w_fwd_j;
    logic               w_fwd_k;

    // Lowest-index free entry; uses registered valids only, so an entry freed
    // by this cycle's issue is not offered to dispatch until next cycle.
    always_comb begin : p_free
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = PTR_W'(i);
            end
        end
    end

    always_comb begin : p_rdy
        for (int i = 0; i < ENTRIES; i++) begin
            w_rdy[i] = r_valid[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
        end
    end

    // First ready entry at or after the round-robin pointer, wrapping.
    always_comb begin : p_sel
        int v;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        v           = 0;
        for (int k = 0; k < ENTRIES; k++) begin
            v = int'(r_ptr) + k;
            if (v >= ENTRIES) begin
                v = v - ENTRIES;
            end
            if (!w_sel_found && w_rdy[PTR_W'(v)]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = PTR_W'(v);
            end
        end
    end

    assign w_ptr_next = (w_sel_idx == PTR_W'(ENTRIES - 1)) ? '0 : w_sel_idx + 1'b1;

    // A held result blocks issue unless it is granted in the same cycle.
    assign w_issue    = w_sel_found && (!r_res_valid || res_grant) && !flush;
    assign disp_ready = w_free_found;
    assign w_disp     = disp_valid && w_free_found;
    assign w_cdb_hit  = cdb_valid && (cdb_tag != '0);
    assign w_fwd_j    = w_cdb_hit && (disp_qj == cdb_tag);
    assign w_fwd_k    = w_cdb_hit && (disp_qk == cdb_tag);

    assign fu_op = w_issue ? r_op[w_sel_idx] : 1'b0;
    assign fu_a  = w_issue ? r_vj[w_sel_idx] : '0;
    assign fu_b  = w_issue ? r_vk[w_sel_idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_op    <= '0;
            r_ptr   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_qj[i]  <= '0;
                r_qk[i]  <= '0;
                r_vj[i]  <= '0;
                r_vk[i]  <= '0;
                r_tag[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            r_op    <= '0;
            r_ptr   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_qj[i]  <= '0;
                r_qk[i]  <= '0;
                r_vj[i]  <= '0;
                r_vk[i]  <= '0;
                r_tag[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                // Wakeup: both operands may match the same broadcast.
                if (r_valid[i] && w_cdb_hit) begin
                    if (r_qj[i] == cdb_tag) begin
                        r_qj[i] <= '0;
                        r_vj[i] <= cdb_data;
                    end
                    if (r_qk[i] == cdb_tag) begin
                        r_qk[i] <= '0;
                        r_vk[i] <= cdb_data;
                    end
                end
                if (w_issue && (w_sel_idx == PTR_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end
                // The dispatch target is always a free entry, so it never
                // collides with the issued or woken entries above.
                if (w_disp && (w_free_idx == PTR_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_op[i]    <= disp_op;
                    r_tag[i]   <= disp_tag;
                    r_qj[i]    <= w_fwd_j ? '0 : disp_qj;
                    r_vj[i]    <= w_fwd_j ? cdb_data : disp_vj;
                    r_qk[i]    <= w_fwd_k ? '0 : disp_qk;
                    r_vk[i]    <= w_fwd_k ? cdb_data : disp_vk;
                end
            end
            if (w_issue) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_data  <= '0;
            r_res_bout  <= 1'b0;
        end else if (flush) begin
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_data  <= '0;
            r_res_bout  <= 1'b0;
        end else if (w_issue) begin
            r_res_valid <= 1'b1;
            r_res_tag   <= r_tag[w_sel_idx];
            r_res_data  <= fu_res;
            // The datapath borrow is meaningless for add.
            r_res_bout  <= fu_bout & r_op[w_sel_idx];
        end else if (res_grant) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_tag   = r_res_tag;
    assign res_data  = r_res_data;
    assign res_bout  = r_res_bout;

`ifdef INT_RS_PERF_EN
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_issue <= '0;
            r_perf_full  <= '0;
        end else if (flush) begin
            r_perf_issue <= '0;
            r_perf_full  <= '0;
        end else begin
            if (w_issue && (r_perf_issue != '1)) begin
                r_perf_issue <= r_perf_issue + 32'd1;
            end
            if (disp_valid && !w_free_found && (r_perf_full != '1)) begin
                r_perf_full <= r_perf_full + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = r_perf_issue;
    assign perf_full_cnt  = r_perf_full;
`endif

endmodule
`default_nettype wire
